pipelined_xor_add_decoder: RTL and testbench
============================================

Name: pipelined_xor_add_decoder

Overview:
- Receive-side inverse of the team's pipelined encoder, which computes q = (a + b) XOR c.
- Given the encoded word q plus the side operands a and c, the block recovers b = (q XOR c) - a, modulo 2^WIDTH.
- It is a 3-stage pipeline with valid/ready handshakes on both sides and a wrapping count of delivered results. It sits directly downstream of the encoder and feeds checkers or consumers.

Parameters:
WIDTH, 4, data width of q, a, c and b.
COUNT_W, 8, width of the delivered-result counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
q_in  input  WIDTH  encoded word
a_in  input  WIDTH  first operand (a) used at encode
c_in  input  WIDTH  XOR mask (c) used at encode
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
b_out  output  WIDTH  recovered operand b
out_valid  output  1  b_out valid
out_ready  input  1  downstream accepts b_out
count_out  output  COUNT_W  number of completed output handshakes, wrapping

Behaviour:
- Reset: synchronous. On a clk edge with rst=1, all stage data and valid registers, b_out, out_valid and count_out go to 0.
  - rst overrides any in-flight beats. Beats in the pipe are discarded, not delivered.
  - in_ready is 1 during reset and immediately after it, since it is derived from out_valid=0.
- Handshake:
  - An input transfer occurs when in_valid & in_ready at the clk edge.
  - An output transfer occurs when out_valid & out_ready at the clk edge.
- Stall: stall = out_valid & ~out_ready, and in_ready = ~stall (combinational).
  - While stalled, every stage register holds, including b_out/out_valid.
  - Upstream inputs are ignored while stalled.
- Pipeline, advancing only when not stalled:
  - S1: register q, a, c; v1 <= in_valid.
  - S2: x <= q1 ^ c1; a2 <= a1; v2 <= v1.
  - S3: b_out <= x - a2, truncated to WIDTH bits (mod 2^WIDTH); out_valid <= v2.
- Latency: exactly 3 clk edges from an input transfer to out_valid=1 with that result, when there is no backpressure.
  - Throughput is 1 beat per cycle.
  - Bubbles (in_valid=0) propagate as invalid slots; they are not compressed.
- Ordering: results leave in acceptance order. No beat is lost or duplicated across any stall pattern.
- Counter: count_out increments by 1 on each output transfer. It wraps from 2^COUNT_W-1 to 0 and is otherwise held.
- Simultaneous events:
  - An output transfer and a new input on the same edge are both legal; the pipe advances.
  - rst takes priority over both.
- Data lanes of invalid slots are don't-care, but must not change count_out or out_valid.

Test Plan:
- Basic decode (WIDTH=4): q=14, a=3, c=6, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 exactly 3 edges later with b_out=5; count_out=1 afterwards.
- Wrap-around arithmetic: q=10, a=12, c=9 -> b_out=7, since (10^9)=3 and 3-12 mod 16 = 7.
- Streaming: 16 back-to-back beats produced by the reference model (a+b)^c over random a, b, c -> b_out equals the original b in order; out_valid is continuously high for 16 cycles starting 3 edges after the first beat; count_out=16.
- Backpressure: stream 6 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 throughout the stall, b_out/out_valid are stable, and all 6 results are delivered in order with none lost or duplicated.
- Reset mid-operation: assert rst for one edge with 3 beats in flight -> out_valid=0, b_out=0, count_out=0 next cycle; no stale beat ever appears afterwards; in_ready=1.
- Counter wrap (COUNT_W=2): 5 output transfers -> count_out sequence 1,2,3,0,1.

Source files
------------

// File: rtl/pipelined_xor_add_decoder.sv
// Recovers b = (q ^ c) - a (mod 2^WIDTH) from the encoder's q=(a+b)^c and side operands a, c.
// Latency: 3 clk edges from input transfer to out_valid; 1 beat/cycle throughput.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready in the same cycle.
module pipelined_xor_add_decoder #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   q_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   c_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   b_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count_out
);

    // Stage 1 holds the raw captured beat.
    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] c;
    } s1_dat_t;

    // Stage 2 holds the unmasked sum (a+b) and the operand still to subtract.
    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] a;
    } s2_dat_t;

    s1_dat_t s1_dat;
    logic    s1_vld;
    s2_dat_t s2_dat;
    logic    s2_vld;
    logic    stall;
    logic    out_xfer;

    // A full output register that is not being taken blocks the whole pipe;
    // there is no skid buffer, so the stall reaches upstream combinationally.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign out_xfer = out_valid & out_ready;

    // Stage 1: capture the beat; bubbles enter as invalid slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else if (!stall) begin
            s1_dat <= '{q: q_in, a: a_in, c: c_in};
            s1_vld <= in_valid;
        end
    end

    // Stage 2: undo the XOR mask, forward a alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_dat <= '0;
            s2_vld <= 1'b0;
        end else if (!stall) begin
            s2_dat <= '{x: s1_dat.q ^ s1_dat.c, a: s1_dat.a};
            s2_vld <= s1_vld;
        end
    end

    // Stage 3: undo the addition; subtraction wraps naturally at WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_out     <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            b_out     <= s2_dat.x - s2_dat.a;
            out_valid <= s2_vld;
        end
    end

    // Count completed output handshakes, wrapping at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
        end else if (out_xfer) begin
            count_out <= count_out + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_xor_add_decoder.sv
// Directed bench for pipelined_xor_add_decoder: decode, wrap arithmetic, streaming,
// backpressure, mid-flight reset and narrow-counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pipelined_xor_add_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in, a_in, c_in;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [3:0] b_out;
    logic [7:0] count_out;
    logic       in_ready2, out_valid2;
    logic [3:0] b_out2;
    logic [1:0] count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_xor_add_decoder #(.WIDTH(4), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .a_in(a_in), .c_in(c_in),
        .in_valid(in_valid), .in_ready(in_ready), .b_out(b_out),
        .out_valid(out_valid), .out_ready(out_ready), .count_out(count_out)
    );

    pipelined_xor_add_decoder #(.WIDTH(4), .COUNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .q_in(q_in), .a_in(a_in), .c_in(c_in),
        .in_valid(in_valid), .in_ready(in_ready2), .b_out(b_out2),
        .out_valid(out_valid2), .out_ready(out_ready), .count_out(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enc(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] s;
        s = a + b;
        return s ^ c;
    endfunction

    task automatic drive(input logic v, input logic [3:0] q, input logic [3:0] a, input logic [3:0] c);
        in_valid = v;
        q_in     = q;
        a_in     = a;
        c_in     = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] sa[16], sb[16], sc[16];
    logic [3:0] bp_a[6] = '{4'd1, 4'd7, 4'd15, 4'd4, 4'd9, 4'd0};
    logic [3:0] bp_b[6] = '{4'd2, 4'd11, 4'd3, 4'd14, 4'd6, 4'd8};
    logic [3:0] bp_c[6] = '{4'd5, 4'd0, 4'd12, 4'd7, 4'd10, 4'd15};
    int         wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        int sent, rcv, stall_cnt;
        logic [3:0] hold_b;

        out_ready = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        tick();
        tick();

        // Reset state.
        chk("rst_out_valid", out_valid, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Basic decode: (14^6)-3 = 5, valid on the 3rd edge.
        drive(1'b1, 4'd14, 4'd3, 4'd6);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        chk("basic_lat_e1", out_valid, 0);
        tick();
        chk("basic_lat_e2", out_valid, 0);
        tick();
        chk("basic_valid_e3", out_valid, 1);
        chk("basic_b", b_out, 5);
        tick();
        chk("basic_drained", out_valid, 0);
        chk("basic_count", count_out, 1);

        // Wrap-around subtraction: (10^9)-12 = 3-12 = 7 mod 16.
        drive(1'b1, 4'd10, 4'd12, 4'd9);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk("wrap_valid", out_valid, 1);
        chk("wrap_b", b_out, 7);
        tick();
        chk("wrap_count", count_out, 2);

        // Streaming: 16 back-to-back beats encoded by the reference (a+b)^c.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sa[i] = 4'($urandom_range(0, 15));
            sb[i] = 4'($urandom_range(0, 15));
            sc[i] = 4'($urandom_range(0, 15));
        end
        for (int t = 0; t < 18; t++) begin
            if (t < 16) drive(1'b1, enc(sa[t], sb[t], sc[t]), sa[t], sc[t]);
            else        drive(1'b0, 4'd0, 4'd0, 4'd0);
            tick();
            if (t < 2) begin
                chk($sformatf("stream_idle_%0d", t), out_valid, 0);
            end else begin
                chk($sformatf("stream_valid_%0d", t), out_valid, 1);
                chk($sformatf("stream_b_%0d", t - 2), b_out, sb[t - 2]);
            end
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_count", count_out, 16);
        chk("stream_count_w2", count2, 0);

        // Backpressure: 6 beats, out_ready low for 5 cycles mid-stream.
        do_reset();
        sent = 0;
        rcv = 0;
        stall_cnt = 0;
        hold_b = 4'd0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            if (sent < 6) drive(1'b1, enc(bp_a[sent], bp_b[sent], bp_c[sent]), bp_a[sent], bp_c[sent]);
            else          drive(1'b0, 4'd0, 4'd0, 4'd0);
            #1;
            if (!out_ready) begin
                stall_cnt++;
                chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, 0);
                chk($sformatf("bp_hold_valid_c%0d", cyc), out_valid, 1);
                if (stall_cnt == 1) hold_b = b_out;
                else chk($sformatf("bp_hold_b_c%0d", cyc), b_out, hold_b);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_b_%0d", rcv), b_out, bp_b[rcv]);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        chk("bp_stall_cycles", stall_cnt, 5);
        chk("bp_delivered", rcv, 6);
        chk("bp_no_dup", out_valid, 0);
        chk("bp_count", count_out, 6);

        // Mid-flight reset with 3 beats in the pipe.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, enc(4'd3, 4'd3, 4'd3), 4'd3, 4'd3);
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_b_out", b_out, 0);
        chk("mrst_count", count_out, 0);
        chk("mrst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mrst_no_stale_%0d", i), out_valid, 0);
        end
        chk("mrst_count_after", count_out, 0);

        // Narrow counter wrap: 5 transfers give 1,2,3,0,1.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            if (t < 5) drive(1'b1, enc(4'(t), 4'd1, 4'd2), 4'(t), 4'd2);
            else       drive(1'b0, 4'd0, 4'd0, 4'd0);
            tick();
            if (t >= 3) chk($sformatf("cw_count2_%0d", t - 3), count2, wrap_exp[t - 3]);
        end
        chk("cw_count_wide", count_out, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
